// File: rtl/sn74x173_pkg.sv
// Shared constants, types and helpers for the sn74x173 register.
// The width default lives here so the top, the bus interface and the
// bench all agree on it without repeating the literal.
package sn74x173_pkg;

    localparam int DEFAULT_N = 4;
    localparam int MAX_N     = 64;

    typedef logic [DEFAULT_N-1:0] data_t;

    // Both enable pairs on this part are active-low and must both be
    // asserted, so the same two-input test is used for load and output.
    function automatic logic bothLow(input logic a, input logic b);
        return ~a & ~b;
    endfunction

endpackage

// File: rtl/sn74x173_if.sv
// Bus bundle for the sn74x173 register: data in, the two enable pairs,
// clear and the tri-state data out. The master side drives the register
// inputs and observes q; the slave side is the register itself.
interface sn74x173_if
    import sn74x173_pkg::*;
#(
    parameter int N = DEFAULT_N
) ();

    logic         clr;
    logic [N-1:0] d;
    logic         g1_;
    logic         g2_;
    logic         m;
    logic         n;
    wire  [N-1:0] q;

    modport master (
        output clr,
        output d,
        output g1_,
        output g2_,
        output m,
        output n,
        input  q
    );

    modport slave (
        input  clr,
        input  d,
        input  g1_,
        input  g2_,
        input  m,
        input  n,
        output q
    );

endinterface

// File: rtl/sn74x173_bit.sv
// One bit slice of the sn74x173: load/hold gating, the flop with a
// synchronous clear and the tri-state output driver. The enables are
// decoded once in the top and fanned out to every slice.
// Debug taps are present only when SN74X173_DEBUG_EN is defined.
module sn74x173_bit (
    input  logic clk,
    input  logic clr,
    input  logic i_d,
    input  logic i_inEn,
    input  logic i_inEn_,
    input  logic i_outEn,
    output wire  o_q
`ifdef SN74X173_DEBUG_EN
    ,
    output wire  o_qInt,
    output wire  o_dInt,
    output wire  o_top,
    output wire  o_bot
`endif
);

    logic r_q;
    logic w_top;
    logic w_bot;
    logic w_dInt;

    // The next-state value is an AND-OR mux: new data when loading,
    // the current bit fed back when holding.
    assign w_top  = i_d & i_inEn;
    assign w_bot  = r_q & i_inEn_;
    assign w_dInt = w_top | w_bot;

    // Clear wins over load; otherwise take the gated next-state value.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_q <= 1'b0;
        end else begin
            r_q <= w_dInt;
        end
    end

    // The output enable only gates the pin, never the stored value.
    assign o_q = i_outEn ? r_q : 1'bz;

`ifdef SN74X173_DEBUG_EN
    assign o_qInt = r_q;
    assign o_dInt = w_dInt;
    assign o_top  = w_top;
    assign o_bot  = w_bot;
`endif

endmodule

// File: rtl/sn74x173.sv
// sn74x173: N-bit register with active-low data-enable pair (g1_, g2_),
// synchronous active-high clear and a tri-state output gated by the
// active-low output-enable pair (m, n).
// Define SN74X173_DEBUG_EN to expose the internal nets as extra ports;
// without it only q is observable and its behaviour is identical.
module sn74x173
    import sn74x173_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] d,
    input  logic         g1_,
    input  logic         g2_,
    input  logic         m,
    input  logic         n,
    output wire  [N-1:0] q
`ifdef SN74X173_DEBUG_EN
    ,
    output wire          clk_,
    output wire          in_en,
    output wire          in_en_,
    output wire          out_en,
    output wire  [N-1:0] q_int,
    output wire  [N-1:0] d_int,
    output wire  [N-1:0] top,
    output wire  [N-1:0] bot
`endif
);

    logic w_inEn;
    logic w_inEn_;
    logic w_outEn;

    // Enables are shared by every slice, so decode them here once.
    assign w_inEn  = bothLow(g1_, g2_);
    assign w_inEn_ = ~w_inEn;
    assign w_outEn = bothLow(m, n);

    for (genvar i = 0; i < N; i++) begin : gBit
        sn74x173_bit uBit (
            .clk     (clk),
            .clr     (clr),
            .i_d     (d[i]),
            .i_inEn  (w_inEn),
            .i_inEn_ (w_inEn_),
            .i_outEn (w_outEn),
            .o_q     (q[i])
`ifdef SN74X173_DEBUG_EN
            ,
            .o_qInt  (q_int[i]),
            .o_dInt  (d_int[i]),
            .o_top   (top[i]),
            .o_bot   (bot[i])
`endif
        );
    end

`ifdef SN74X173_DEBUG_EN
    assign clk_   = ~clk;
    assign in_en  = w_inEn;
    assign in_en_ = w_inEn_;
    assign out_en = w_outEn;
`endif

endmodule

// File: tb/tb_sn74x173.sv
// Scoreboard bench for sn74x173. Stimulus computes the expected response
// from a plain behavioural model and queues it; an independent monitor
// pops each entry and compares against the DUT. A disabled q reads as
// all ones through pull-ups on the bus.
module tb_sn74x173;
    import sn74x173_pkg::*;

    localparam int N = DEFAULT_N;

    typedef struct {
        bit           comb;
        string        name;
        logic [N-1:0] q;
        logic [N-1:0] qInt;
        logic [N-1:0] top;
        logic [N-1:0] bot;
        logic [N-1:0] dInt;
        logic         inEn;
        logic         outEn;
    } exp_t;

    logic         clk = 1'b0;
    int           total = 0;
    int           bad = 0;
    int           pending = 0;
    exp_t         expQ[$];
    logic [N-1:0] mReg = '0;
    bit           mKnown = 1'b0;
    wire  [N-1:0] qBus;

    sn74x173_if #(.N(N)) bus ();

`ifdef SN74X173_DEBUG_EN
    wire          dClk_;
    wire          dInEn;
    wire          dInEn_;
    wire          dOutEn;
    wire  [N-1:0] dQInt;
    wire  [N-1:0] dDInt;
    wire  [N-1:0] dTop;
    wire  [N-1:0] dBot;
`endif

    always #20 clk = ~clk;

    for (genvar i = 0; i < N; i++) begin : gPull
        pullup (qBus[i]);
    end

    assign bus.q = qBus;

    sn74x173 #(.N(N)) dut (
        .clk    (clk),
        .clr    (bus.clr),
        .d      (bus.d),
        .g1_    (bus.g1_),
        .g2_    (bus.g2_),
        .m      (bus.m),
        .n      (bus.n),
        .q      (qBus)
`ifdef SN74X173_DEBUG_EN
        ,
        .clk_   (dClk_),
        .in_en  (dInEn),
        .in_en_ (dInEn_),
        .out_en (dOutEn),
        .q_int  (dQInt),
        .d_int  (dDInt),
        .top    (dTop),
        .bot    (dBot)
`endif
    );

    // Expected observable state given the stored value and present inputs.
    function automatic exp_t makeExp(input bit comb, input string name, input logic [N-1:0] regv);
        exp_t e;
        e.comb  = comb;
        e.name  = name;
        e.inEn  = (bus.g1_ == 1'b0) && (bus.g2_ == 1'b0);
        e.outEn = (bus.m == 1'b0) && (bus.n == 1'b0);
        e.qInt  = regv;
        e.top   = e.inEn ? bus.d : '0;
        e.bot   = e.inEn ? '0 : regv;
        e.dInt  = e.inEn ? bus.d : regv;
        e.q     = e.outEn ? regv : '1;
        return e;
    endfunction

    task automatic pushExp(input exp_t e);
        expQ.push_back(e);
        pending++;
    endtask

    task automatic compareField(input string name, input string field,
                                input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s.%s got=%0h want=%0h", name, field, got, want);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField(e.name, "q", 64'(qBus), 64'(e.q));
`ifdef SN74X173_DEBUG_EN
        compareField(e.name, "q_int",  64'(dQInt),  64'(e.qInt));
        compareField(e.name, "in_en",  64'(dInEn),  64'(e.inEn));
        compareField(e.name, "in_en_", 64'(dInEn_), 64'(~e.inEn));
        compareField(e.name, "out_en", 64'(dOutEn), 64'(e.outEn));
        compareField(e.name, "top",    64'(dTop),   64'(e.top));
        compareField(e.name, "bot",    64'(dBot),   64'(e.bot));
        compareField(e.name, "d_int",  64'(dDInt),  64'(e.dInt));
        compareField(e.name, "clk_",   64'(dClk_),  64'(~clk));
`endif
    endtask

    // Drive one cycle's inputs from the low phase, check the pre-edge
    // state, then advance the model across the edge and queue the result.
    task automatic applyStimulus(input logic clrV, input logic [N-1:0] dV,
                                 input logic g1V, input logic g2V,
                                 input logic mV, input logic nV, input string name);
        bus.clr = clrV;
        bus.d   = dV;
        bus.g1_ = g1V;
        bus.g2_ = g2V;
        bus.m   = mV;
        bus.n   = nV;
        #2;
        if (mKnown) pushExp(makeExp(1'b1, {name, "/pre"}, mReg));
        #3;
        if (clrV) begin
            mReg   = '0;
            mKnown = 1'b1;
        end else if (!g1V && !g2V) begin
            mReg   = dV;
            mKnown = 1'b1;
        end
        if (mKnown) pushExp(makeExp(1'b0, name, mReg));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic setOe(input logic mV, input logic nV, input string name);
        bus.m = mV;
        bus.n = nV;
        #1;
        pushExp(makeExp(1'b1, name, mReg));
        #3;
    endtask

    task automatic clrPulse(input string name);
        bus.clr = 1'b1;
        #1;
        bus.clr = 1'b0;
        #1;
        pushExp(makeExp(1'b1, name, mReg));
        #3;
    endtask

    // Monitor: combinational entries are checked right away, edge entries
    // just after the next rising edge.
    initial begin
        exp_t cur;
        forever begin
            wait (expQ.size() != 0);
            cur = expQ.pop_front();
            if (cur.comb) begin
                #1;
            end else begin
                @(posedge clk);
                #1;
            end
            checkOutput(cur);
            pending--;
        end
    end

    // Hard stop in case the stimulus never completes.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        data_t      a;
        logic [3:0] c;
        bus.clr = 1'b0;
        bus.d   = '0;
        bus.g1_ = 1'b1;
        bus.g2_ = 1'b1;
        bus.m   = 1'b1;
        bus.n   = 1'b1;
        @(negedge clk);

        applyStimulus(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
        applyStimulus(1'b1, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b0, "resetHiz");
        a = 4'b1010;
        applyStimulus(1'b0, a, 1'b0, 1'b1, 1'b0, 1'b0, "oneEnable");
        applyStimulus(1'b0, a, 1'b0, 1'b0, 1'b1, 1'b1, "loadHiz");
        setOe(1'b0, 1'b1, "oeMOnly");
        setOe(1'b0, 1'b0, "oeBoth");
        a = 4'b0101;
        applyStimulus(1'b0, a, 1'b0, 1'b1, 1'b0, 1'b0, "hold1");
        applyStimulus(1'b0, a, 1'b0, 1'b1, 1'b0, 1'b0, "hold2");
        applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, "clrPriority");
        applyStimulus(1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, "reload");
        clrPulse("clrBetween");
        applyStimulus(1'b0, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, "afterPulse");

        for (int i = 0; i < 16; i++) begin
            c = 4'(i);
            applyStimulus(1'b0, N'($urandom()), c[3], c[2], c[1], c[0],
                          $sformatf("combo%0d", i));
        end

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0)
                setOe(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rndOe%0d", k));
            if ($urandom_range(0, 15) == 0)
                clrPulse($sformatf("rndPulse%0d", k));
            applyStimulus($urandom_range(0, 7) == 0, N'($urandom()),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $sformatf("rnd%0d", k));
        end

        for (int w = 0; w < 20 && pending != 0; w++) @(negedge clk);
        if (pending != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain got=%0d want=0", pending);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sn74x173.md
SN74X173 -- requirements
Module: sn74x173

Interface
REQ-001 SHALL have parameter N, default 4: register width in bits, legal range 1..64.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port clr, input, 1 bit: reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-004 SHALL have port d, input, N bits: parallel data in.
REQ-005 SHALL have ports g1_ and g2_, input, 1 bit each: active-low data-enable pair.
REQ-006 SHALL have ports m and n, input, 1 bit each: active-low output-enable pair.
REQ-007 SHALL have port q, output, N bits: tri-state data out.
REQ-008 SHALL provide the following debug outputs:
- clk_ (1 bit): inverted clk.
- in_en (1 bit): load enable.
- in_en_ (1 bit): inverted in_en.
- out_en (1 bit): output enable.
- q_int (N bits): internal register.
- d_int (N bits): next-state value.
- top (N bits): load term.
- bot (N bits): hold term.

Function
REQ-009 SHALL drive in_en = NOT g1_ AND NOT g2_, and in_en_ = NOT in_en.
REQ-010 SHALL drive out_en = NOT m AND NOT n.
REQ-011 SHALL drive clk_ = NOT clk, combinationally.
REQ-012 SHALL form the next-state value bitwise as:
- top = d AND in_en, replicated to N bits.
- bot = q_int AND in_en_, replicated to N bits.
- d_int = top OR bot.
REQ-013 SHALL, on each rising clk edge with clr=0, set q_int to d_int; this loads d when in_en=1 and holds otherwise.
REQ-014 SHALL make load latency one edge: d sampled at edge k is visible on q_int immediately after edge k.
REQ-015 SHALL drive q = q_int when out_en=1, and all bits high-impedance when out_en=0.
REQ-016 SHALL make q respond to m and n combinationally, with no clock dependence.
REQ-017 SHALL leave q_int value unaffected by the output-enable state; a disabled output still loads and holds.
REQ-018 SHALL make all debug outputs purely combinational, except q_int, which is the register.

Reset
REQ-019 SHALL, on a rising clk edge with clr=1, set q_int to all zeros regardless of g1_, g2_ and d.
REQ-020 SHALL give clr priority over load when both are active at the same edge.
REQ-021 SHALL NOT clear on clr assertion between edges, because the reset is synchronous.
REQ-022 SHALL present q as all zeros after reset when out_en=1, and high-impedance otherwise.
REQ-023 SHALL treat q_int as undefined before the first clr or load edge; the bench SHALL NOT check it earlier.

Configuration
REQ-024 SHALL compile the debug ports clk_, in_en, in_en_, out_en, q_int, d_int, top and bot only when SN74X173_DEBUG_EN is defined.
REQ-025 SHALL, without SN74X173_DEBUG_EN, omit those ports while keeping identical functional behaviour on q.

Structure
REQ-026 SHALL place the default width constant (4) and an N-bit data typedef in package sn74x173_pkg.
REQ-027 SHALL implement one sub-module, sn74x173_bit, instantiated N times; each instance contains:
- the load/hold gating (top/bot/d_int) for its bit,
- the flop with synchronous clear,
- the tri-state driver.
REQ-028 SHALL compute the shared enables once in the top level.

Verification
REQ-029 SHALL cover load with one enable high: d=1010, g1_=0, g2_=1, clr=0, rising edge -> q_int unchanged, in_en=0.
REQ-030 SHALL cover load: g1_=0, g2_=0, d=1010, rising edge -> q_int=1010 after the edge; with m=1 and n=1, q is high-impedance.
REQ-031 SHALL cover output enable: m=0, n=1 -> q stays high-impedance; then n=0 -> q=1010 immediately, with no edge required.
REQ-032 SHALL cover hold: g2_=1, d=0101, two edges -> q_int stays 1010.
REQ-033 SHALL cover clear priority: clr=1, g1_=0, g2_=0, d=1111 -> q_int=0000 after the edge and q=0000 with out_en=1; clr pulsed between edges -> no change.
REQ-034 SHALL cover the debug equations: every combination of g1_, g2_, m, n -> in_en, in_en_, out_en, top, bot and d_int match REQ-009 to REQ-012.
